// File: rtl/rv32_onehot_decoder.sv
// RV32I decode stage: one registered slot turning a raw instruction into the ALU's one-hot
// opcode vector, register fields and immediate. Define DECODER_PERF_CNT_EN for transfer counters.
module rv32_onehot_decoder #(
   parameter int XLEN = 32,
   parameter int OH_W = 37
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OH_W-1:0] instructions,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] out_pc,
   output logic            illegal
`ifdef DECODER_PERF_CNT_EN
   ,
   output logic [31:0]     decoded_cnt,
   output logic [31:0]     illegal_cnt
`endif
);

   localparam int I_ADD   = 0;
   localparam int I_SUB   = 1;
   localparam int I_SLL   = 2;
   localparam int I_SLT   = 3;
   localparam int I_SLTU  = 4;
   localparam int I_XOR   = 5;
   localparam int I_SRL   = 6;
   localparam int I_SRA   = 7;
   localparam int I_OR    = 8;
   localparam int I_AND   = 9;
   localparam int I_ADDI  = 10;
   localparam int I_SLTI  = 11;
   localparam int I_SLTIU = 12;
   localparam int I_XORI  = 13;
   localparam int I_ORI   = 14;
   localparam int I_ANDI  = 15;
   localparam int I_SLLI  = 16;
   localparam int I_SRLI  = 17;
   localparam int I_SRAI  = 18;
   localparam int I_LB    = 19;
   localparam int I_LH    = 20;
   localparam int I_LW    = 21;
   localparam int I_LBU   = 22;
   localparam int I_LHU   = 23;
   localparam int I_SB    = 24;
   localparam int I_SH    = 25;
   localparam int I_SW    = 26;
   localparam int I_BEQ   = 27;
   localparam int I_BNE   = 28;
   localparam int I_BLT   = 29;
   localparam int I_BGE   = 30;
   localparam int I_BLTU  = 31;
   localparam int I_BGEU  = 32;
   localparam int I_LUI   = 33;
   localparam int I_AUIPC = 34;
   localparam int I_JAL   = 35;
   localparam int I_JALR  = 36;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_ZERO = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_sh;

   assign imm_i  = XLEN'($signed(in_instr[31:20]));
   assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   assign imm_sh = XLEN'(in_instr[24:20]);

   logic [OH_W-1:0] dec_oh;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   // An opcode match implies instr[1:0] == 2'b11, so compressed encodings fall out as illegal.
   always_comb begin
      dec_oh  = '0;
      dec_imm = '0;
      unique case (opcode)
         OP_REG: begin
            if (funct7 == F7_ZERO) begin
               case (funct3)
                  3'd0: dec_oh[I_ADD]  = 1'b1;
                  3'd1: dec_oh[I_SLL]  = 1'b1;
                  3'd2: dec_oh[I_SLT]  = 1'b1;
                  3'd3: dec_oh[I_SLTU] = 1'b1;
                  3'd4: dec_oh[I_XOR]  = 1'b1;
                  3'd5: dec_oh[I_SRL]  = 1'b1;
                  3'd6: dec_oh[I_OR]   = 1'b1;
                  default: dec_oh[I_AND] = 1'b1;
               endcase
            end else if (funct7 == F7_ALT) begin
               case (funct3)
                  3'd0: dec_oh[I_SUB] = 1'b1;
                  3'd5: dec_oh[I_SRA] = 1'b1;
                  default: ;
               endcase
            end
         end
         OP_IMM: begin
            dec_imm = imm_i;
            case (funct3)
               3'd0: dec_oh[I_ADDI]  = 1'b1;
               3'd2: dec_oh[I_SLTI]  = 1'b1;
               3'd3: dec_oh[I_SLTIU] = 1'b1;
               3'd4: dec_oh[I_XORI]  = 1'b1;
               3'd6: dec_oh[I_ORI]   = 1'b1;
               3'd7: dec_oh[I_ANDI]  = 1'b1;
               3'd1: begin
                  dec_imm = imm_sh;
                  if (funct7 == F7_ZERO) dec_oh[I_SLLI] = 1'b1;
               end
               default: begin
                  dec_imm = imm_sh;
                  if (funct7 == F7_ZERO) dec_oh[I_SRLI] = 1'b1;
                  else if (funct7 == F7_ALT) dec_oh[I_SRAI] = 1'b1;
               end
            endcase
         end
         OP_LOAD: begin
            dec_imm = imm_i;
            case (funct3)
               3'd0: dec_oh[I_LB]  = 1'b1;
               3'd1: dec_oh[I_LH]  = 1'b1;
               3'd2: dec_oh[I_LW]  = 1'b1;
               3'd4: dec_oh[I_LBU] = 1'b1;
               3'd5: dec_oh[I_LHU] = 1'b1;
               default: ;
            endcase
         end
         OP_STORE: begin
            dec_imm = imm_s;
            case (funct3)
               3'd0: dec_oh[I_SB] = 1'b1;
               3'd1: dec_oh[I_SH] = 1'b1;
               3'd2: dec_oh[I_SW] = 1'b1;
               default: ;
            endcase
         end
         OP_BRANCH: begin
            dec_imm = imm_b;
            case (funct3)
               3'd0: dec_oh[I_BEQ]  = 1'b1;
               3'd1: dec_oh[I_BNE]  = 1'b1;
               3'd4: dec_oh[I_BLT]  = 1'b1;
               3'd5: dec_oh[I_BGE]  = 1'b1;
               3'd6: dec_oh[I_BLTU] = 1'b1;
               3'd7: dec_oh[I_BGEU] = 1'b1;
               default: ;
            endcase
         end
         OP_LUI: begin
            dec_imm = imm_u;
            dec_oh[I_LUI] = 1'b1;
         end
         OP_AUIPC: begin
            dec_imm = imm_u;
            dec_oh[I_AUIPC] = 1'b1;
         end
         OP_JAL: begin
            dec_imm = imm_j;
            dec_oh[I_JAL] = 1'b1;
         end
         OP_JALR: begin
            dec_imm = imm_i;
            if (funct3 == 3'd0) dec_oh[I_JALR] = 1'b1;
         end
         default: ;
      endcase
      // Illegal words carry no immediate so the ALU never sees stale offset bits.
      if (dec_oh == '0) dec_imm = '0;
   end

   assign dec_illegal = (dec_oh == '0);

   // Handshake: a side transfers on an edge where its valid and ready are both high.
   // in_ready depends only on the output slot, never on in_valid; flush overrides both sides.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         instructions <= '0;
         rs1_addr     <= '0;
         rs2_addr     <= '0;
         rd_addr      <= '0;
         imm          <= '0;
         out_pc       <= '0;
         illegal      <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid    <= 1'b1;
         instructions <= dec_oh;
         rs1_addr     <= in_instr[19:15];
         rs2_addr     <= in_instr[24:20];
         rd_addr      <= in_instr[11:7];
         imm          <= dec_imm;
         out_pc       <= in_pc;
         illegal      <= dec_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DECODER_PERF_CNT_EN
   // Counts downstream transfers even in a flush cycle: the bundle was already consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         decoded_cnt <= '0;
         illegal_cnt <= '0;
      end else if (out_valid && out_ready) begin
         decoded_cnt <= decoded_cnt + 32'd1;
         if (illegal) illegal_cnt <= illegal_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rv32_onehot_decoder.sv
// Bench for rv32_onehot_decoder: directed decode/handshake cases plus randomized traffic
// checked against a table-driven RV32I reference model and an expected-bundle queue.
module tb_rv32_onehot_decoder;
   localparam int XLEN = 32;
   localparam int OH_W = 37;
   localparam int BW   = 1 + OH_W + 15 + 2 * XLEN;

   localparam int F_R  = 0;
   localparam int F_I  = 1;
   localparam int F_SH = 2;
   localparam int F_S  = 3;
   localparam int F_B  = 4;
   localparam int F_U  = 5;
   localparam int F_J  = 6;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [OH_W-1:0] instructions;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] out_pc;
   logic            illegal;
`ifdef DECODER_PERF_CNT_EN
   logic [31:0]     decoded_cnt;
   logic [31:0]     illegal_cnt;
   logic [31:0]     m_dcnt;
   logic [31:0]     m_icnt;
`endif

   rv32_onehot_decoder #(.XLEN(XLEN), .OH_W(OH_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .instructions(instructions),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .imm(imm), .out_pc(out_pc), .illegal(illegal)
`ifdef DECODER_PERF_CNT_EN
      , .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_xfer   = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] obs;
   assign obs = {illegal, instructions, rs1_addr, rs2_addr, rd_addr, imm, out_pc};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: instruction table (opcode, funct3, funct7, format); -1 = don't care
   int t_op[OH_W];
   int t_f3[OH_W];
   int t_f7[OH_W];
   int t_fmt[OH_W];

   task automatic set_entry(input int i, input int op, input int f3, input int f7, input int fmt);
      t_op[i] = op; t_f3[i] = f3; t_f7[i] = f7; t_fmt[i] = fmt;
   endtask

   task automatic build_table();
      int f3r[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
      int f7r[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
      int f3i[9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
      int f7i[9]  = '{-1, -1, -1, -1, -1, -1, 0, 0, 32};
      int f3l[5]  = '{0, 1, 2, 4, 5};
      int f3b[6]  = '{0, 1, 4, 5, 6, 7};
      for (int i = 0; i < 10; i++) set_entry(i, 'h33, f3r[i], f7r[i], F_R);
      for (int i = 0; i < 9; i++)  set_entry(10 + i, 'h13, f3i[i], f7i[i], (i >= 6) ? F_SH : F_I);
      for (int i = 0; i < 5; i++)  set_entry(19 + i, 'h03, f3l[i], -1, F_I);
      for (int i = 0; i < 3; i++)  set_entry(24 + i, 'h23, i, -1, F_S);
      for (int i = 0; i < 6; i++)  set_entry(27 + i, 'h63, f3b[i], -1, F_B);
      set_entry(33, 'h37, -1, -1, F_U);
      set_entry(34, 'h17, -1, -1, F_U);
      set_entry(35, 'h6f, -1, -1, F_J);
      set_entry(36, 'h67, 0, -1, F_I);
   endtask

   function automatic logic [BW-1:0] model(input logic [31:0] w, input logic [XLEN-1:0] pc);
      int idx = -1;
      int v = 0;
      logic [OH_W-1:0] one = 1;
      logic [OH_W-1:0] oh = '0;
      for (int i = 0; i < OH_W; i++)
         if (int'(w[6:0]) == t_op[i] && (t_f3[i] < 0 || int'(w[14:12]) == t_f3[i]) &&
             (t_f7[i] < 0 || int'(w[31:25]) == t_f7[i]))
            idx = i;
      if (idx >= 0) begin
         oh = one << idx;
         case (t_fmt[idx])
            F_I:  begin v = int'(w[31:20]); if (v >= 2048) v -= 4096; end
            F_SH: v = int'(w[24:20]);
            F_S:  begin v = int'(w[31:25]) * 32 + int'(w[11:7]); if (v >= 2048) v -= 4096; end
            F_B:  begin
               v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
               if (v >= 4096) v -= 8192;
            end
            F_U:  v = int'(w[31:12]) << 12;
            F_J:  begin
               v = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
               if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
         endcase
      end
      return {idx < 0, oh, w[19:15], w[24:20], w[11:7], XLEN'(v), pc};
   endfunction

   // scoreboard: every negedge compares the DUT against the expected queue
   logic mon_held;
   logic mon_acc;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
`ifdef DECODER_PERF_CNT_EN
         m_dcnt = 0;
         m_icnt = 0;
`endif
      end else begin
         mon_held = (exp_q.size() != 0);
         check("out_valid", out_valid, mon_held);
         check("in_ready", in_ready, !mon_held || out_ready);
         check("onehot", $countones(instructions) <= 1, 1);
         if (mon_held) check("bundle", obs, exp_q[0]);
`ifdef DECODER_PERF_CNT_EN
         check("decoded_cnt", decoded_cnt, m_dcnt);
         check("illegal_cnt", illegal_cnt, m_icnt);
         if (mon_held && out_ready) begin
            m_dcnt++;
            if (exp_q[0][BW-1]) m_icnt++;
         end
`endif
         if (flush) begin
            exp_q.delete();
         end else begin
            mon_acc = in_valid && (!mon_held || out_ready);
            if (mon_held && out_ready) begin
               void'(exp_q.pop_front());
               n_xfer++;
            end
            if (mon_acc) exp_q.push_back(model(in_instr, in_pc));
         end
      end
   end

   // driver tasks (all start from posedge+1)
   task automatic send(input logic [31:0] w, input logic [XLEN-1:0] pc);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = w; in_pc = pc;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_dec(input string tag, input int bit_idx, input logic [XLEN-1:0] exp_imm);
      logic [OH_W-1:0] one = 1;
      logic [OH_W-1:0] exp_oh;
      exp_oh = (bit_idx < 0) ? '0 : (one << bit_idx);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_oh"}, instructions, exp_oh);
      check({tag, "_imm"}, imm, exp_imm);
      check({tag, "_illegal"}, illegal, bit_idx < 0);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h0f, 7'h73};
      logic [31:0] w = $urandom;
      if ($urandom_range(0, 7) == 0) return w;
      w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return w;
   endfunction

   int n0;
   logic acc_r;

   initial begin
      build_table();
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
      acc_r = 1'b0;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_oh", instructions, 0);
      check("rst_regs", {rs1_addr, rs2_addr, rd_addr}, 0);
      check("rst_imm", imm, 0);
      check("rst_pc", out_pc, 0);
      check("rst_illegal", illegal, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("rst_in_ready", in_ready, 1);

      // illegal encodings
      send(32'h0000_0000, 32'h0000_0040);
      chk_dec("zero", -1, 0);
      send(32'h0000_0073, 32'h0000_0044);
      chk_dec("ecall", -1, 0);
      repeat (3) @(negedge clk);
`ifdef DECODER_PERF_CNT_EN
      check("perf_decoded", decoded_cnt, 2);
      check("perf_illegal", illegal_cnt, 2);
`endif

      // ALU and immediate decodes
      send(32'h0020_81B3, 32'h0000_1000);
      chk_dec("add", 0, 0);
      check("add_rd", rd_addr, 3);
      check("add_rs1", rs1_addr, 1);
      check("add_rs2", rs2_addr, 2);
      check("add_pc", out_pc, 32'h0000_1000);
      send(32'h4020_81B3, 32'h0000_1004);
      chk_dec("sub", 1, 0);
      send(32'hFFF0_0093, 32'h0000_1008);
      chk_dec("addi", 10, 32'hFFFF_FFFF);
      send(32'h4032_D293, 32'h0000_100C);
      chk_dec("srai", 18, 3);
      send(32'h1234_50B7, 32'h0000_1010);
      chk_dec("lui", 33, 32'h1234_5000);

      // backpressure
      @(posedge clk); #1;
      out_ready = 1'b0;
      n0 = n_xfer;
      send(32'h0020_81B3, 32'h0000_2000);
      fork
         begin
            send(32'h4020_81B3, 32'h0000_2004);
            send(32'hFFF0_0093, 32'h0000_2008);
         end
         begin
            repeat (4) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_hold_oh", instructions, 1);
               check("bp_hold_pc", out_pc, 32'h0000_2000);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);
      check("bp_count", n_xfer - n0, 3);

      // flush with a held bundle and a same-cycle input
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'h1234_50B7, 32'h0000_3000);
      @(negedge clk);
      check("flush_pre_valid", out_valid, 1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = 32'h4020_81B3; in_pc = 32'h0000_3004; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_valid", out_valid, 0);
      n0 = n_xfer;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("flush_drop", n_xfer - n0, 0);

      // asynchronous reset while stalled
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'hFFF0_0093, 32'h0000_4000);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_oh", instructions, 0);
      check("arst_imm", imm, 0);
      check("arst_pc", out_pc, 0);
      check("arst_regs", {rs1_addr, rs2_addr, rd_addr}, 0);
      check("arst_illegal", illegal, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("arst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      send(32'h0020_81B3, 32'h0000_4004);
      chk_dec("post_rst_add", 0, 0);
      check("post_rst_rd", rd_addr, 3);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (!in_valid || acc_r) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = gen_instr();
            in_pc    = $urandom;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 30) == 0);
         @(negedge clk);
         acc_r = in_valid && in_ready && !flush;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
